// File: rtl/bcd_pkg.sv
// Shared constants for the BCD/binary conversion blocks: FSM encoding and
// the per-digit reverse double-dabble correction constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX       = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] DD_ADJ_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] DD_ADJ_VAL    = 4'd3;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD nibble correction for reverse double-dabble: a digit that received
// a halved ten (value >= 8) is pulled back by 3 so it stays a decimal digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= DD_ADJ_THRESH) ? (i_digit - DD_ADJ_VAL) : i_digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter: one right-shift/correct step per clock,
// start/done handshake, invalid digits flagged without converting.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_i,
    output logic [BIN_W-1:0]              num_o,
    output logic                          done_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    state_t             r_state, w_next;
    logic [BCD_W-1:0]   r_bcd, w_bcd_shift, w_bcd_adj;
    logic [BIN_W-1:0]   r_bin, w_bin_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_num;
    logic               r_err;
    logic               w_bad;
    logic               w_last;

    assign {w_bcd_shift, w_bin_shift} = {r_bcd, r_bin} >> 1;
    assign w_last = (r_cnt == LAST_STEP);

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (w_bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(bcd_i[i*BCD_DIGIT_W +: BCD_DIGIT_W])) w_bad = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next = w_bad ? DONE : SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
            r_num <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        if (w_bad) begin
                            r_num <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_bcd <= bcd_i;
                            r_bin <= '0;
                            r_cnt <= '0;
                            r_err <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_shift;
                    r_cnt <= r_cnt + 1'b1;
                    // Final step: the last bit lands in the binary register now.
                    if (w_last) r_num <= w_bin_shift;
                end
                default: ;
            endcase
        end
    end

    assign num_o  = r_num;
    assign err_o  = r_err;
    assign done_o = (r_state == DONE);
    assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: expected results queued at issue time and
// checked by an independent monitor whenever done_o pulses.
module tb_bcd_to_bin;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b0;
    logic                  start_i = 1'b0;
    logic [4*DIGITS-1:0]   bcd_i = '0;
    logic [BIN_W-1:0]      num_o;
    logic                  done_o;
    logic                  busy_o;
    logic                  err_o;

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .bcd_i   (bcd_i),
        .num_o   (num_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [BIN_W-1:0] num;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;
    int   cyc = 0;
    bit   prev_done = 0;
    bit   chk_space = 0;
    bit   have_last = 0;
    int   last_cyc = 0;

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done_o and checks pulse shape.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (done_o) begin
                exp_t e;
                n_done++;
                check("done_width", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("num_o", int'(num_o), int'(e.num));
                    check("err_o", int'(err_o), int'(e.err));
                end
                if (chk_space) begin
                    if (have_last) check("done_spacing", cyc - last_cyc, BIN_W + 2);
                    have_last = 1;
                    last_cyc = cyc;
                end
            end
            prev_done = done_o;
        end else begin
            prev_done = 0;
        end
    end

    task automatic push(input int num, input bit err);
        exp_t e;
        e.num = BIN_W'(num);
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [15:0] v);
        @(negedge clk_i);
        bcd_i = v;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Counts negedges with busy_o high, starting at the current negedge.
    task automatic measure_busy(output int n);
        n = 0;
        while (busy_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        if (n >= 200) check("busy_timeout", n, 0);
    endtask

    task automatic wait_idle();
        int n;
        measure_busy(n);
        @(negedge clk_i);
    endtask

    logic [15:0] seq_v[9] = '{16'h0000, 16'h0001, 16'h0009, 16'h0010, 16'h0099,
                              16'h0100, 16'h0999, 16'h1000, 16'h9998};
    int          seq_d[9] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998};

    initial begin
        int nb;
        int d0;

        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_num", int'(num_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_busy", int'(busy_o), 0);

        // 1: zero operand, latency and busy length
        push(0, 0);
        do_start(16'h0000);
        measure_busy(nb);
        check("busy_len_valid", nb, BIN_W + 1);
        check("n_done_t1", n_done, 1);

        // 2: full-scale and mixed digits
        push(9999, 0);
        do_start(16'h9999);
        wait_idle();
        push(1234, 0);
        do_start(16'h1234);
        wait_idle();

        // 3: invalid digit, then recovery
        push(0, 1);
        do_start(16'h12A4);
        measure_busy(nb);
        check("busy_len_err", nb, 1);
        check("err_held_idle", int'(err_o), 1);
        push(42, 0);
        do_start(16'h0042);
        wait_idle();
        check("err_cleared", int'(err_o), 0);

        // 4: operand change and start pulse mid-conversion are ignored
        d0 = n_done;
        push(500, 0);
        do_start(16'h0500);
        repeat (4) @(negedge clk_i);
        bcd_i = 16'h9999;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk_i);
        check("one_done_t4", n_done - d0, 1);
        check("num_held_idle", int'(num_o), 500);

        // 5: reset mid-conversion aborts silently
        d0 = n_done;
        do_start(16'h8191);
        repeat (6) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_num", int'(num_o), 0);
        check("abort_err", int'(err_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_done", int'(done_o), 0);
        repeat (20) @(negedge clk_i);
        check("abort_no_done", n_done - d0, 0);
        push(8191, 0);
        do_start(16'h8191);
        wait_idle();

        // 6: start held high, back-to-back conversions
        d0 = n_done;
        for (int i = 0; i < 9; i++) push(seq_d[i], 0);
        chk_space = 1;
        have_last = 0;
        for (int i = 0; i < 9; i++) begin
            int t = 0;
            while (busy_o && t < 200) begin
                t++;
                @(negedge clk_i);
            end
            if (t >= 200) check("seq_timeout", t, 0);
            bcd_i = seq_v[i];
            start_i = 1'b1;
            @(negedge clk_i);
        end
        measure_busy(nb);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_space = 0;
        check("seq_done_count", n_done - d0, 9);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
